// File: rtl/ps2_rx_fifo_if.sv
// Byte stream from the PS/2 receiver FIFO to the scan-code consumer (valid/ready).
// master drives rx_valid/rx_data, slave drives rx_ready; a byte moves when both are high.
interface ps2_rx_fifo_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: debounced pins, 11-bit frame check, FWFT byte FIFO (valid/ready).
// Byte visible DEBOUNCE_CYCLES+4 clk after the stop-bit edge; a full FIFO drops bytes with err_overflow; PS2_FRAME_TIMEOUT_EN adds a stalled-frame timeout.
module debouncer #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic reset_low,
  input  logic din,
  output logic dout
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Output follows the synchronised pin only after CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module edge_detector (
  input  logic clk,
  input  logic reset_low,
  input  logic din,
  output logic fall
);
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_low) prev <= 1'b1;
    else            prev <= din;
  end

  assign fall = prev & ~din;
endmodule

module ps2_rx_fifo #(
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ps2_clk_pin,
  input  logic                             ps2_data_pin,
  ps2_rx_fifo_if.master                    rx,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             busy,
  output logic                             err_parity,
  output logic                             err_frame,
  output logic                             err_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_rx_fifo: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic clk_db, data_db, fall;

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clk (
    .clk(clk), .reset_low(~reset), .din(ps2_clk_pin), .dout(clk_db)
  );
  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_data (
    .clk(clk), .reset_low(~reset), .din(ps2_data_pin), .dout(data_db)
  );
  edge_detector u_fall (
    .clk(clk), .reset_low(~reset), .din(clk_db), .fall(fall)
  );

  logic [3:0] bit_idx;
  logic [8:0] shreg;
  logic       parity;
  logic       push_vld;
  logic [7:0] push_dat;
  logic       tmo_hit;
  logic       frame_ok;

  assign busy     = (bit_idx != 4'd0);
  assign frame_ok = ~shreg[0] & data_db;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx    <= '0;
      shreg      <= '0;
      parity     <= 1'b0;
      push_vld   <= 1'b0;
      push_dat   <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      push_vld   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (fall) begin
        if (bit_idx == 4'd10) begin
          bit_idx <= '0;
          shreg   <= '0;
          parity  <= 1'b0;
          // Framing errors take precedence; parity is only judged on a well-framed byte.
          if (!frame_ok)    err_frame  <= 1'b1;
          else if (!parity) err_parity <= 1'b1;
          else begin
            push_vld <= 1'b1;
            push_dat <= shreg[8:1];
          end
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx <= 4'd8) shreg <= {data_db, shreg[8:1]};
          if (bit_idx != 4'd0) parity <= parity ^ data_db;
        end
      end else if (tmo_hit) begin
        bit_idx   <= '0;
        shreg     <= '0;
        parity    <= 1'b0;
        err_frame <= 1'b1;
      end
    end
  end

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = busy && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || fall || !busy || tmo_hit) tmo_cnt <= '0;
    else                                    tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push;

  assign full         = (fifo_level == LW'(FIFO_DEPTH));
  assign pop          = rx.rx_valid & rx.rx_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push         = push_vld & (~full | pop);
  assign err_overflow = push_vld & full & ~pop;

  assign rx.rx_valid = (fifo_level != '0);
  assign rx.rx_data  = rx.rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good/bad frames, FIFO fill/overflow/drain, reset mid-frame, optional timeout.
module tb_ps2_rx_fifo;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_pin = 1'b1;
  logic       ps2_data_pin = 1'b1;
  logic [2:0] fifo_level;
  logic       busy, err_parity, err_frame, err_overflow;

  ps2_rx_fifo_if rx_if ();

  ps2_rx_fifo #(
    .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk_pin(ps2_clk_pin), .ps2_data_pin(ps2_data_pin),
    .rx(rx_if), .fifo_level(fifo_level), .busy(busy),
    .err_parity(err_parity), .err_frame(err_frame), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt_par = 0, cnt_frm = 0, cnt_ovf = 0;
  int b_par, b_frm, b_ovf;

  always @(posedge clk) begin
    if (err_parity)   cnt_par <= cnt_par + 1;
    if (err_frame)    cnt_frm <= cnt_frm + 1;
    if (err_overflow) cnt_ovf <= cnt_ovf + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_par = cnt_par; b_frm = cnt_frm; b_ovf = cnt_ovf;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_ok, input logic stop);
    return {stop, (~^d) ^ ~par_ok, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_pin = f[i];
      wait_clk(10);
      ps2_clk_pin = 1'b0;
      wait_clk(20);
      ps2_clk_pin = 1'b1;
      wait_clk(10);
    end
    ps2_data_pin = 1'b1;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, rx_if.rx_valid, 1'b1);
    check({tag, "_data"}, rx_if.rx_data, exp);
    rx_if.rx_ready = 1'b1;
    wait_clk(1);
    rx_if.rx_ready = 1'b0;
  endtask

  // Holds rx_ready for exactly the cycle in which the frame's byte is pushed.
  task automatic ready_on_push();
    int n;
    n = 0;
    while (!busy && n < 2000) begin wait_clk(1); n++; end
    while (busy && n < 2000)  begin wait_clk(1); n++; end
    check("push_window_found", n < 2000, 1'b1);
    rx_if.rx_ready = 1'b1;
    wait_clk(1);
    rx_if.rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    rx_if.rx_ready = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check("rst_valid", rx_if.rx_valid, 1'b0);
    check("rst_data", rx_if.rx_data, 8'h00);
    check("rst_level", fifo_level, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {err_parity, err_frame, err_overflow}, 3'b000);
    reset = 1'b0;
    wait_clk(5);

    // Good 0x1C, with stop edge sent by hand to measure latency.
    mark();
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 10);
    wait_clk(10);
    ps2_clk_pin = 1'b0;
    n = 0;
    while (!rx_if.rx_valid && n < 50) begin wait_clk(1); n++; end
    check("latency_in_bound", (n <= DEB + 4) && rx_if.rx_valid, 1'b1);
    wait_clk(20);
    ps2_clk_pin = 1'b1;
    wait_clk(10);
    @(negedge clk);
    check("1c_level", fifo_level, 3'd1);
    check("1c_errs", (cnt_par - b_par) + (cnt_frm - b_frm), 0);
    pop_expect("1c", 8'h1C);
    @(negedge clk);
    check("1c_empty_valid", rx_if.rx_valid, 1'b0);
    check("1c_empty_level", fifo_level, 3'd0);

    // 0x5A with wrong parity bit 0.
    mark();
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11);
    @(negedge clk);
    check("5a_par_pulses", cnt_par - b_par, 1);
    check("5a_frm_pulses", cnt_frm - b_frm, 0);
    check("5a_valid", rx_if.rx_valid, 1'b0);

    // 0xF0 with stop bit 0.
    mark();
    send_bits(mk_frame(8'hF0, 1'b1, 1'b0), 11);
    @(negedge clk);
    check("f0_frm_pulses", cnt_frm - b_frm, 1);
    check("f0_par_pulses", cnt_par - b_par, 0);
    check("f0_level", fifo_level, 3'd0);

    // Fill past capacity with no consumer.
    mark();
    for (int i = 1; i <= 5; i++) send_bits(mk_frame(i[7:0], 1'b1, 1'b1), 11);
    @(negedge clk);
    check("fill_level", fifo_level, 3'd4);
    check("fill_ovf_pulses", cnt_ovf - b_ovf, 1);
    for (int i = 1; i <= 4; i++) pop_expect("drain", i[7:0]);
    @(negedge clk);
    check("drain_level", fifo_level, 3'd0);

    // Refill, then push into a full FIFO while popping the head.
    for (int i = 1; i <= 4; i++) send_bits(mk_frame(i[7:0], 1'b1, 1'b1), 11);
    mark();
    fork
      send_bits(mk_frame(8'h06, 1'b1, 1'b1), 11);
      ready_on_push();
    join
    @(negedge clk);
    check("full_pp_ovf", cnt_ovf - b_ovf, 0);
    check("full_pp_level", fifo_level, 3'd4);
    pop_expect("full_pp", 8'h02);
    pop_expect("full_pp", 8'h03);
    pop_expect("full_pp", 8'h04);
    pop_expect("full_pp_tail", 8'h06);

    // Reset in the middle of a frame aborts silently.
    send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 4);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    mark();
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_errs", (cnt_par - b_par) + (cnt_frm - b_frm) + (cnt_ovf - b_ovf), 0);
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    @(negedge clk);
    check("post_rst_level", fifo_level, 3'd1);
    pop_expect("post_rst", 8'h1C);

`ifdef PS2_FRAME_TIMEOUT_EN
    send_bits(mk_frame(8'h33, 1'b1, 1'b1), 4);
    mark();
    n = 0;
    while (busy && n < 1100) begin wait_clk(1); n++; end
    check("tmo_window", (n >= 900) && (n <= 1001), 1'b1);
    wait_clk(2);
    check("tmo_frm_pulses", cnt_frm - b_frm, 1);
    check("tmo_par_pulses", cnt_par - b_par, 0);
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    pop_expect("tmo_resync", 8'h1C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
